// File: rtl/versatile_fifo_pkg.sv
// Shared sizing helpers for the single-clock FIFO controller.
//   depth_f   : RAM depth for a given address width
//   ptr_w_f   : pointer width (address bits plus one wrap bit)
//   lvls_ok   : legality of the almost-empty / almost-full thresholds
package versatile_fifo_pkg;

  function automatic int unsigned depth_f(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned ptr_w_f(input int unsigned aw);
    return aw + 32'd1;
  endfunction

  // AEMPTY_LVL in 0..DEPTH-1, AFULL_LVL in 1..DEPTH
  function automatic bit lvls_ok(input int unsigned aw,
                                 input int unsigned ae,
                                 input int unsigned af);
    return (ae <= depth_f(aw) - 32'd1) && (af >= 32'd1) && (af <= depth_f(aw));
  endfunction

endpackage

// File: rtl/versatile_fifo_ptr.sv
// Wrap-bit pointer counter for the FIFO controller.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset (to 0)
//   clear  : synchronous flush (to 0), lower priority than rst
//   inc    : advance by one, wrapping modulo 2^WIDTH
//   ptr    : registered pointer value
//   nxt_c  : combinational value ptr takes on the next edge
module versatile_fifo_ptr
  import versatile_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = ptr_w_f(4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr,
  output logic [WIDTH-1:0] nxt_c
);

  // Next pointer value
  always_comb begin
    nxt_c = ptr;
    if (rst || clear) begin
      nxt_c = '0;
    end else if (inc) begin
      nxt_c = ptr + WIDTH'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    ptr <= nxt_c;
  end

endmodule

// File: rtl/versatile_fifo_sync_ctrl.sv
// Single-clock FIFO controller and status generator for a 2^ADDR_WIDTH-deep
// dual-port RAM. Full/empty come from a wrap bit on each pointer; fill and
// all four flags are registered from the next-state pointers.
// Optional feature macro: VERSATILE_FIFO_ERR_EN adds sticky ovf/udf outputs.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   clear               : synchronous flush, same effect as rst
//   wr, rd              : write / read requests
//   wr_ack, rd_ack      : accepted this cycle (RAM enables, combinational)
//   wadr, radr          : RAM write / read addresses
//   fill                : occupancy 0..DEPTH
//   fifo_empty/full     : registered empty / full
//   fifo_aempty/afull   : registered almost-empty / almost-full
//   ovf, udf            : sticky overflow / underflow (macro only)
module versatile_fifo_sync_ctrl
  import versatile_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AEMPTY_LVL = 2,
  parameter int unsigned AFULL_LVL  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_ack,
  output logic                  rd_ack,
  output logic [ADDR_WIDTH-1:0] wadr,
  output logic [ADDR_WIDTH-1:0] radr,
  output logic [ADDR_WIDTH:0]   fill,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  fifo_aempty,
  output logic                  fifo_afull
`ifdef VERSATILE_FIFO_ERR_EN
  ,
  output logic                  ovf,
  output logic                  udf
`endif
);

  localparam int unsigned DEPTH = depth_f(ADDR_WIDTH);
  localparam int unsigned PW    = ptr_w_f(ADDR_WIDTH);

  generate
    if (!lvls_ok(ADDR_WIDTH, AEMPTY_LVL, AFULL_LVL)) begin : g_bad_lvls
      $error("versatile_fifo_sync_ctrl: AEMPTY_LVL/AFULL_LVL out of range");
    end
  endgenerate

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW-1:0] wp_nxt;
  logic [PW-1:0] rp_nxt;
  logic [PW-1:0] next_fill;

  // Acks depend only on registered flags, so no request-to-ack loop exists
  assign wr_ack = wr & ~fifo_full  & ~rst & ~clear;
  assign rd_ack = rd & ~fifo_empty & ~rst & ~clear;

  versatile_fifo_ptr #(.WIDTH(PW)) u_wp (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (wr_ack),
    .ptr   (wp),
    .nxt_c (wp_nxt)
  );

  versatile_fifo_ptr #(.WIDTH(PW)) u_rp (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (rd_ack),
    .ptr   (rp),
    .nxt_c (rp_nxt)
  );

  assign wadr = wp[ADDR_WIDTH-1:0];
  assign radr = rp[ADDR_WIDTH-1:0];

  // Modular pointer difference keeps fill == wp - rp by construction
  assign next_fill = wp_nxt - rp_nxt;

  // Fill and flags, all from the next-state occupancy
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fill        <= '0;
      fifo_empty  <= 1'b1;
      fifo_full   <= 1'b0;
      fifo_aempty <= 1'b1;
      fifo_afull  <= 1'b0;
    end else begin
      fill        <= next_fill;
      fifo_empty  <= (next_fill == '0);
      fifo_full   <= (next_fill == PW'(DEPTH));
      fifo_aempty <= (next_fill <= PW'(AEMPTY_LVL));
      fifo_afull  <= (next_fill >= PW'(AFULL_LVL));
    end
  end

`ifdef VERSATILE_FIFO_ERR_EN
  // Sticky error flags, cleared only by rst or clear
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr && fifo_full)  ovf <= 1'b1;
      if (rd && fifo_empty) udf <= 1'b1;
    end
  end
`else
  // Rejected requests are dropped silently; no error state is kept
`endif

endmodule
